// File: rtl/bus_int_ctl.sv
// bus_int_ctl -- priority interrupt controller for a single CPU.
//
// Gathers NSRC level-sensitive device interrupt requests. Each source has a
// fixed 3-bit bus request level. A source competes only while its level is
// above the CPU priority. The controller presents one winner to the CPU,
// pulses that device's acknowledge when the CPU accepts, and then waits a
// bounded time for the device to drop its request before it arbitrates again.
//
// Optional feature (compile-time macro INT_RR_EN):
//   defined   - round-robin tie-break among sources at the same level; the
//               pointer advances past the winner when the CPU acknowledges
//   undefined - the lowest-index source wins ties; no pointer state
//
// Parameters:
//   NSRC      number of interrupt sources
//   SRC_LEVEL packed 3-bit request level per source (source i at [3i+2:3i])
//   WAIT_MAX  maximum cycles spent waiting for a serviced request to drop
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   irq          per-source interrupt request (level)
//   vec_in       per-source vector byte, source i at [8i+7:8i]
//   cpu_ipl      current CPU priority level
//   cpu_int_ack  CPU accepts the presented interrupt (one-cycle pulse)
//   cpu_int_req  interrupt presented to the CPU (registered)
//   cpu_vector   vector of the presented interrupt, 0 when none (registered)
//   dev_ack      one-hot, one-cycle acknowledge to the serviced device (registered)

// Per-source qualifier: a source competes only while it requests and its
// level is above the CPU priority.
module bus_int_src #(
  parameter logic [2:0] LEVEL = 3'd4
) (
  input  logic       irq,
  input  logic [2:0] cpu_ipl,
  output logic       elig,
  output logic [2:0] lvl
);
  assign lvl  = LEVEL;
  assign elig = irq && (LEVEL > cpu_ipl);
endmodule

module bus_int_ctl #(
  parameter int               NSRC      = 8,
  parameter logic [3*NSRC-1:0] SRC_LEVEL = 24'h924926,
  parameter int               WAIT_MAX  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NSRC-1:0]   irq,
  input  logic [8*NSRC-1:0] vec_in,
  input  logic [2:0]        cpu_ipl,
  input  logic              cpu_int_ack,
  output logic              cpu_int_req,
  output logic [7:0]        cpu_vector,
  output logic [NSRC-1:0]   dev_ack
);
  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_DROP} state_t;

  // Latched winner: kept stable for the whole transaction.
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [7:0]    vec;
  } win_t;

  state_t                 state_q, state_nxt;
  win_t                   win_q, win_nxt;
  logic [CW-1:0]          wait_q, wait_nxt;
  logic [NSRC-1:0]        elig;
  logic [NSRC-1:0][2:0]   lvl;
  logic [NSRC-1:0][7:0]   vec_arr;
  logic [NSRC-1:0]        ack_oh;
  logic                   arb_any;
  logic [IW-1:0]          arb_idx;
  logic [2:0]             arb_lvl;
  int                     j;

  assign vec_arr = vec_in;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    bus_int_src #(.LEVEL(SRC_LEVEL[3*gi +: 3])) u_src (
      .irq     (irq[gi]),
      .cpu_ipl (cpu_ipl),
      .elig    (elig[gi]),
      .lvl     (lvl[gi])
    );
  end

`ifdef INT_RR_EN
  logic [IW-1:0] rr_ptr;
`endif

  // Arbiter: scan sources in tie-break order and keep the first one seen at
  // the highest level (strict '>' makes earlier scan positions win ties).
  // Round-robin starts the scan at the pointer and wraps.
  always_comb begin
    arb_any = 1'b0;
    arb_idx = '0;
    arb_lvl = '0;
    j       = 0;
    for (int k = 0; k < NSRC; k++) begin
`ifdef INT_RR_EN
      j = int'(rr_ptr) + k;
      if (j >= NSRC) j = j - NSRC;
`else
      j = k;
`endif
      if (elig[j] && (!arb_any || lvl[j] > arb_lvl)) begin
        arb_any = 1'b1;
        arb_idx = IW'(j);
        arb_lvl = lvl[j];
      end
    end
  end

  always_comb begin
    ack_oh             = '0;
    ack_oh[win_q.idx]  = 1'b1;
  end

  always_comb begin
    state_nxt = state_q;
    win_nxt   = win_q;
    wait_nxt  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          win_nxt.idx = arb_idx;
          win_nxt.vec = vec_arr[arb_idx];
          state_nxt   = S_REQ;
        end
      end
      S_REQ: begin
        // Ack beats withdrawal when both happen on the same edge; a newly
        // arrived higher source waits for the next IDLE.
        if (cpu_int_ack)            state_nxt = S_ACK;
        else if (!elig[win_q.idx])  state_nxt = S_IDLE;
      end
      S_ACK: begin
        wait_nxt  = '0;
        state_nxt = S_DROP;
      end
      S_DROP: begin
        // Bounded wait so a stuck request cannot lock the controller.
        if (!irq[win_q.idx] || wait_q == CW'(WAIT_MAX - 1)) begin
          wait_nxt  = '0;
          state_nxt = S_IDLE;
        end else begin
          wait_nxt = wait_q + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_nxt;
      win_q   <= win_nxt;
      wait_q  <= wait_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_int_req <= 1'b0;
      cpu_vector  <= '0;
      dev_ack     <= '0;
    end else begin
      cpu_int_req <= (state_nxt == S_REQ);
      cpu_vector  <= (state_nxt == S_REQ) ? win_nxt.vec : 8'h00;
      dev_ack     <= (state_nxt == S_ACK) ? ack_oh : '0;
    end
  end

`ifdef INT_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (state_q == S_REQ && state_nxt == S_ACK) begin
      rr_ptr <= (win_q.idx == IW'(NSRC - 1)) ? '0 : win_q.idx + IW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bus_int_ctl.sv
// Directed bench for bus_int_ctl (default parameters). Works with or without
// INT_RR_EN; only the expected tie-break order differs.
module tb_bus_int_ctl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  irq;
  logic [63:0] vec_in;
  logic [2:0]  cpu_ipl;
  logic        cpu_int_ack;
  logic        cpu_int_req;
  logic [7:0]  cpu_vector;
  logic [7:0]  dev_ack;

  int n_chk  = 0;
  int n_fail = 0;
  int wait_c;
  logic [7:0] exp_ord [4];

  always #5 clk = ~clk;

  bus_int_ctl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .irq         (irq),
    .vec_in      (vec_in),
    .cpu_ipl     (cpu_ipl),
    .cpu_int_ack (cpu_int_ack),
    .cpu_int_req (cpu_int_req),
    .cpu_vector  (cpu_vector),
    .dev_ack     (dev_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
`ifdef INT_RR_EN
    exp_ord[0] = 8'h02; exp_ord[1] = 8'h04; exp_ord[2] = 8'h02; exp_ord[3] = 8'h04;
`else
    exp_ord[0] = 8'h02; exp_ord[1] = 8'h02; exp_ord[2] = 8'h02; exp_ord[3] = 8'h02;
`endif
    reset_n     = 1'b0;
    irq         = 8'h00;
    vec_in      = 64'h87868584_83828140;   // byte0 = 8'o100, byte i = 8'h80+i
    cpu_ipl     = 3'd0;
    cpu_int_ack = 1'b0;
    #12;
    check("rst_req", cpu_int_req, 1'b0);
    check("rst_vec", cpu_vector, 8'h00);
    check("rst_dev_ack", dev_ack, 8'h00);
    tick;
    reset_n = 1'b1;

    // Basic request / ack / drop
    tick;
    check("t1_idle", cpu_int_req, 1'b0);
    irq = 8'h01;
    tick;
    check("t1_req", cpu_int_req, 1'b1);
    check("t1_vec", cpu_vector, 8'h40);
    vec_in[7:0] = 8'hff;
    tick;
    check("t1_req_hold", cpu_int_req, 1'b1);
    check("t1_vec_hold", cpu_vector, 8'h40);
    vec_in[7:0] = 8'h40;
    cpu_int_ack = 1'b1;
    tick;
    check("t1_dev_ack", dev_ack, 8'h01);
    check("t1_req_in_ack", cpu_int_req, 1'b0);
    check("t1_vec_in_ack", cpu_vector, 8'h00);
    cpu_int_ack = 1'b0;
    tick;
    check("t1_dev_ack_once", dev_ack, 8'h00);
    check("t1_vec_drop", cpu_vector, 8'h00);
    irq = 8'h00;
    tick;
    tick;
    check("t1_back_idle", cpu_int_req, 1'b0);

    // Ack in IDLE ignored
    cpu_int_ack = 1'b1;
    tick;
    check("idle_ack_dev", dev_ack, 8'h00);
    check("idle_ack_req", cpu_int_req, 1'b0);
    cpu_int_ack = 1'b0;

    // Level must exceed ipl strictly; tie at level 4
    irq = 8'h06;
    cpu_ipl = 3'd4;
    tick;
    tick;
    check("t2_blocked", cpu_int_req, 1'b0);
    cpu_ipl = 3'd3;
    tick;
    check("t2_req", cpu_int_req, 1'b1);
    check("t2_vec", cpu_vector, 8'h81);
    cpu_int_ack = 1'b1;
    tick;
    check("t2_dev_ack", dev_ack, 8'h02);
    cpu_int_ack = 1'b0;
    irq = 8'h00;
    cpu_ipl = 3'd0;
    tick;
    tick;

    // Highest level wins, withdraw on ipl raise
    irq = 8'h03;
    tick;
    check("t3_req", cpu_int_req, 1'b1);
    check("t3_vec", cpu_vector, 8'h40);
    cpu_ipl = 3'd6;
    tick;
    check("t3_withdraw_req", cpu_int_req, 1'b0);
    check("t3_withdraw_vec", cpu_vector, 8'h00);
    tick;
    tick;
    check("t3_stay_idle", cpu_int_req, 1'b0);
    irq = 8'h00;
    cpu_ipl = 3'd0;
    tick;

    // Ack beats same-cycle drop; DROP bounded by WAIT_MAX
    irq = 8'h01;
    tick;
    check("t4_req", cpu_int_req, 1'b1);
    cpu_int_ack = 1'b1;
    irq = 8'h00;
    tick;
    check("t4_ack_wins", dev_ack, 8'h01);
    cpu_int_ack = 1'b0;
    irq = 8'h01;
    for (int c = 0; c < 5; c++) begin
      tick;
      check("t4_drop_wait", cpu_int_req, 1'b0);
    end
    tick;
    check("t4_represent", cpu_int_req, 1'b1);
    check("t4_represent_vec", cpu_vector, 8'h40);
    cpu_int_ack = 1'b1;
    tick;
    cpu_int_ack = 1'b0;
    irq = 8'h00;
    tick;
    tick;

    // Service order with irq=8'h06 held
    irq = 8'h06;
    for (int r = 0; r < 4; r++) begin
      wait_c = 0;
      while (!cpu_int_req && wait_c < 12) begin
        tick;
        wait_c++;
      end
      check("t5_req", cpu_int_req, 1'b1);
      cpu_int_ack = 1'b1;
      tick;
      check("t5_order", dev_ack, exp_ord[r]);
      cpu_int_ack = 1'b0;
    end
    irq = 8'h00;
    for (int c = 0; c < 8; c++) tick;
    check("t5_drain", cpu_int_req, 1'b0);

    // Async reset during ACK
    irq = 8'h01;
    tick;
    cpu_int_ack = 1'b1;
    tick;
    check("t6_dev_ack", dev_ack, 8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_dev_ack", dev_ack, 8'h00);
    check("t6_rst_req", cpu_int_req, 1'b0);
    check("t6_rst_vec", cpu_vector, 8'h00);
    cpu_int_ack = 1'b0;
    irq = 8'h00;
    #3;
    reset_n = 1'b1;
    tick;
    tick;
    check("t6_post_req", cpu_int_req, 1'b0);
    check("t6_post_dev_ack", dev_ack, 8'h00);

    // Async reset during REQ, restart on first edge after release
    irq = 8'h01;
    tick;
    check("t7_req", cpu_int_req, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_rst_req", cpu_int_req, 1'b0);
    check("t7_rst_vec", cpu_vector, 8'h00);
    #2;
    reset_n = 1'b1;
    tick;
    check("t7_restart_req", cpu_int_req, 1'b1);
    check("t7_restart_vec", cpu_vector, 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
